// File: rtl/chunked_addsub_if.sv
// Handshake bundle for chunked_addsub: operand channel in, result channel out.
// The master modport belongs to the operand source and result consumer; the slave modport belongs to the unit.
interface chunked_addsub_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_op;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_carry;
  logic             out_overflow;
  logic             out_zero;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_result, out_carry, out_overflow, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_result, out_carry, out_overflow, out_zero
  );

endinterface

// File: rtl/chunked_addsub.sv
// Multi-cycle two's-complement add/subtract, CHUNK bits per cycle, LSB chunk first.
// Operand and partial-sum registers shift right each cycle, so only the low chunk is ever summed.
module chunked_addsub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  chunked_addsub_if.slave   bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             op_q, op_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] res_q, res_d;
  logic             cflag_q, cflag_d;
  logic             vflag_q, vflag_d;
  logic             zflag_q, zflag_d;

  logic [WIDTH-1:0]       beff_in;
  logic [CHUNK:0]         chunk_sum;
  logic [WIDTH+CHUNK-1:0] acc_cat;
  logic [WIDTH-1:0]       acc_next;

  // Subtraction is a + ~b + 1; the +1 enters as the initial carry.
  assign beff_in = bus.in_op ? ~bus.in_b : bus.in_b;

  assign chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry_q};

  // New chunk enters at the top; after NCHUNK shifts chunk 0 sits at the LSBs.
  assign acc_cat  = {chunk_sum[CHUNK-1:0], acc_q};
  assign acc_next = acc_cat[WIDTH+CHUNK-1:CHUNK];

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    op_d    = op_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    cflag_d = cflag_q;
    vflag_d = vflag_q;
    zflag_d = zflag_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = CALC;
          a_d     = bus.in_a;
          b_d     = beff_in;
          a_msb_d = bus.in_a[WIDTH-1];
          b_msb_d = beff_in[WIDTH-1];
          op_d    = bus.in_op;
          carry_d = bus.in_op;
          cnt_d   = '0;
        end
      end

      CALC: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        acc_d   = acc_next;
        carry_d = chunk_sum[CHUNK];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          res_d   = acc_next;
          cflag_d = chunk_sum[CHUNK] ^ op_q;
          vflag_d = (a_msb_q == b_msb_q) && (acc_next[WIDTH-1] != a_msb_q);
          zflag_d = ~|acc_next;
        end
      end

      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: datapath registers are reset too, so a reset mid-operation leaves no stale operand or result behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      op_q    <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      cflag_q <= 1'b0;
      vflag_q <= 1'b0;
      zflag_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      cflag_q <= cflag_d;
      vflag_q <= vflag_d;
      zflag_q <= zflag_d;
    end
  end

  assign bus.in_ready     = (state_q == IDLE);
  assign bus.out_valid    = (state_q == DONE);
  assign bus.out_result   = res_q;
  assign bus.out_carry    = cflag_q;
  assign bus.out_overflow = vflag_q;
  assign bus.out_zero     = zflag_q;

  // A stalled result must stay put until the consumer takes it.
  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.out_valid && !bus.out_ready) |=> (bus.out_valid && $stable(bus.out_result)
                                           && $stable(bus.out_carry)
                                           && $stable(bus.out_overflow)
                                           && $stable(bus.out_zero)));

  a_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.in_ready && bus.out_valid));

endmodule

// File: tb/tb_chunked_addsub.sv
// Self-checking bench: 8/4 build with a directed vector table and corner sequences,
// 16/1 build with a directed borrow case and a random sweep against an arithmetic model.
module tb_chunked_addsub;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  chunked_addsub_if #(.WIDTH(8))  if8 ();
  chunked_addsub_if #(.WIDTH(16)) if16 ();

  chunked_addsub #(.WIDTH(8),  .CHUNK(4)) dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  chunked_addsub #(.WIDTH(16), .CHUNK(1)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

  typedef struct {
    logic [15:0] res;
    logic        carry;
    logic        ovf;
    logic        zero;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       op;
    exp_t       e;
  } vec_t;

  exp_t q8[$];
  exp_t q16[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] res, input logic c, input logic v, input logic z);
    exp_t e;
    e.res = res; e.carry = c; e.ovf = v; e.zero = z;
    return e;
  endfunction

  function automatic vec_t mv(input logic [7:0] a, input logic [7:0] b, input logic op, input exp_t e);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.e = e;
    return v;
  endfunction

  // Reference: plain integer arithmetic on the full operands.
  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b, input logic op);
    longint mask, ua, ub, full, sa, sb, s, lim;
    exp_t   e;
    mask  = (longint'(1) << w) - 1;
    ua    = longint'(a) & mask;
    ub    = longint'(b) & mask;
    full  = op ? ua - ub : ua + ub;
    e.res = 16'(full & mask);
    e.carry = op ? (ua < ub) : (((full >> w) & 1) != 0);
    sa    = a[w-1] ? ua - (mask + 1) : ua;
    sb    = b[w-1] ? ub - (mask + 1) : ub;
    s     = op ? sa - sb : sa + sb;
    lim   = longint'(1) << (w - 1);
    e.ovf = (s >= lim) || (s < -lim);
    e.zero = (e.res == 16'h0);
    return e;
  endfunction

  // Scoreboard side: compare whenever an output handshake is about to happen.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && if8.out_valid && if8.out_ready) begin
      check("sb8_expected_pending", q8.size() != 0, 1);
      if (q8.size() != 0) begin
        e = q8.pop_front();
        check("sb8_result",   if8.out_result,   e.res);
        check("sb8_carry",    if8.out_carry,    e.carry);
        check("sb8_overflow", if8.out_overflow, e.ovf);
        check("sb8_zero",     if8.out_zero,     e.zero);
      end
    end
    if (rst_n && if16.out_valid && if16.out_ready) begin
      check("sb16_expected_pending", q16.size() != 0, 1);
      if (q16.size() != 0) begin
        e = q16.pop_front();
        check("sb16_result",   if16.out_result,   e.res);
        check("sb16_carry",    if16.out_carry,    e.carry);
        check("sb16_overflow", if16.out_overflow, e.ovf);
        check("sb16_zero",     if16.out_zero,     e.zero);
      end
    end
  end

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic op, input exp_t e);
    int n;
    if8.in_a = a; if8.in_b = b; if8.in_op = op; if8.in_valid = 1'b1;
    @(negedge clk);
    n = 0;
    while (!if8.in_ready && n < 50) begin @(negedge clk); n++; end
    check("accept8_wait", if8.in_ready, 1);
    if (!if8.in_ready) begin if8.in_valid = 1'b0; return; end
    q8.push_back(e);
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    n = 0;
    while (!if8.out_valid && n < 50) begin @(posedge clk); #1; n++; end
    check("latency8", n, 2);
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic op, input exp_t e);
    int n;
    if16.in_a = a; if16.in_b = b; if16.in_op = op; if16.in_valid = 1'b1;
    @(negedge clk);
    n = 0;
    while (!if16.in_ready && n < 50) begin @(negedge clk); n++; end
    check("accept16_wait", if16.in_ready, 1);
    if (!if16.in_ready) begin if16.in_valid = 1'b0; return; end
    q16.push_back(e);
    @(posedge clk); #1;
    if16.in_valid = 1'b0;
    n = 0;
    while (!if16.out_valid && n < 50) begin @(posedge clk); #1; n++; end
    check("latency16", n, 16);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t        vt [0:10];
    logic [15:0] ra, rb;
    logic        rop;
    int          n;

    vt[0]  = mv(8'h7F, 8'h01, 1'b0, mk(16'h80, 1'b0, 1'b1, 1'b0));
    vt[1]  = mv(8'hFF, 8'h01, 1'b0, mk(16'h00, 1'b1, 1'b0, 1'b1));
    vt[2]  = mv(8'h05, 8'h07, 1'b1, mk(16'hFE, 1'b1, 1'b0, 1'b0));
    vt[3]  = mv(8'h80, 8'h01, 1'b1, mk(16'h7F, 1'b0, 1'b1, 1'b0));
    vt[4]  = mv(8'h3C, 8'h3C, 1'b1, mk(16'h00, 1'b0, 1'b0, 1'b1));
    vt[5]  = mv(8'h80, 8'h80, 1'b0, mk(16'h00, 1'b1, 1'b1, 1'b1));
    vt[6]  = mv(8'h12, 8'h34, 1'b0, mk(16'h46, 1'b0, 1'b0, 1'b0));
    vt[7]  = mv(8'h00, 8'h00, 1'b1, mk(16'h00, 1'b0, 1'b0, 1'b1));
    vt[8]  = mv(8'h0F, 8'h01, 1'b0, mk(16'h10, 1'b0, 1'b0, 1'b0));
    vt[9]  = mv(8'h10, 8'h01, 1'b1, mk(16'h0F, 1'b0, 1'b0, 1'b0));
    vt[10] = mv(8'h7F, 8'hFF, 1'b1, mk(16'h80, 1'b1, 1'b1, 1'b0));

    if8.in_valid  = 1'b0; if8.in_a  = '0; if8.in_b  = '0; if8.in_op  = 1'b0; if8.out_ready  = 1'b1;
    if16.in_valid = 1'b0; if16.in_a = '0; if16.in_b = '0; if16.in_op = 1'b0; if16.out_ready = 1'b1;

    #3;
    check("reset_in_ready",  if8.in_ready,     1);
    check("reset_out_valid", if8.out_valid,    0);
    check("reset_result",    if8.out_result,   0);
    check("reset_flags",     {if8.out_carry, if8.out_overflow, if8.out_zero}, 3'b000);
    check("reset16_ready",   if16.in_ready,    1);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) send8(vt[i].a, vt[i].b, vt[i].op, vt[i].e);

    n = 0;
    while (q8.size() != 0 && n < 50) begin @(posedge clk); n++; end
    @(posedge clk); #1;

    // Backpressure: stalled result with fresh operands waving on the input side.
    if8.out_ready = 1'b0;
    send8(8'h7F, 8'h01, 1'b0, mk(16'h80, 1'b0, 1'b1, 1'b0));
    if8.in_valid = 1'b1; if8.in_a = 8'hAA; if8.in_b = 8'h55; if8.in_op = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", if8.out_valid,  1);
      check("bp_in_ready",  if8.in_ready,   0);
      check("bp_result",    if8.out_result, 8'h80);
      check("bp_flags",     {if8.out_carry, if8.out_overflow, if8.out_zero}, 3'b010);
      @(posedge clk); #1;
    end
    if8.in_a = 8'h10; if8.in_b = 8'h20; if8.in_op = 1'b1;
    q8.push_back(mk(16'hF0, 1'b1, 1'b0, 1'b0));
    if8.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ready", if8.in_ready,  1);
    check("bp_release_valid", if8.out_valid, 0);
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    check("bp_next_accepted", if8.in_ready, 0);
    n = 0;
    while (!if8.out_valid && n < 50) begin @(posedge clk); #1; n++; end
    check("bp_next_latency", n, 2);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of CALC.
    if8.in_a = 8'h33; if8.in_b = 8'h44; if8.in_op = 1'b0; if8.in_valid = 1'b1;
    @(negedge clk);
    check("rst_pre_ready", if8.in_ready, 1);
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("rst_in_ready",  if8.in_ready,   1);
    check("rst_out_valid", if8.out_valid,  0);
    check("rst_result",    if8.out_result, 0);
    check("rst_flags",     {if8.out_carry, if8.out_overflow, if8.out_zero}, 3'b000);
    #2 rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("rst_no_stale", if8.out_valid, 0);
    end
    @(posedge clk); #1;
    send8(8'h0F, 8'h01, 1'b0, mk(16'h10, 1'b0, 1'b0, 1'b0));

    // 16-bit, 1-bit chunk build.
    send16(16'h0000, 16'h0001, 1'b1, mk(16'hFFFF, 1'b1, 1'b0, 1'b0));
    send16(16'h7FFF, 16'h0001, 1'b0, mk(16'h8000, 1'b0, 1'b1, 1'b0));
    for (int i = 0; i < 30; i++) begin
      ra  = 16'($urandom);
      rb  = (i % 7 == 0) ? ra : 16'($urandom);
      rop = 1'($urandom_range(0, 1));
      send16(ra, rb, rop, model(16, ra, rb, rop));
    end

    n = 0;
    while ((q8.size() != 0 || q16.size() != 0) && n < 100) begin @(posedge clk); n++; end
    check("drain8",  q8.size(),  0);
    check("drain16", q16.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chunked_addsub.md
# chunked_addsub

Parametrised, multi-cycle two's-complement add/subtract unit with valid/ready handshakes on input and output. Operands are processed CHUNK bits per cycle, LSB chunk first, with the carry held in a register between chunks. It outputs the result together with carry/borrow, signed-overflow and zero flags. It sits between operand sources and the datapath, and trades latency for a short carry chain.

## Interface
- WIDTH, 8, operand/result width in bits; must be an integer multiple of CHUNK, ≥ 2.
- CHUNK, 4, bits summed per cycle; NCHUNK = WIDTH/CHUNK.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands presented.
- in_ready  output  1  unit can accept; high only in IDLE.
- in_a  input  WIDTH  minuend / first addend.
- in_b  input  WIDTH  subtrahend / second addend.
- in_op  input  1  0 = a+b, 1 = a−b.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts the result.
- out_result  output  WIDTH  (a ± b) mod 2^WIDTH.
- out_carry  output  1  add: carry out of MSB; sub: borrow (1 iff a < b unsigned).
- out_overflow  output  1  signed overflow.
- out_zero  output  1  out_result == 0.

## Operation
- One clock domain. Reset is asynchronous and active-low. All state is cleared on rst_n low, independent of clk.
- FSM states:
  - IDLE: in_ready = 1.
  - CALC: chunk counter runs 0..NCHUNK−1.
  - DONE: out_valid = 1.
- IDLE → CALC on in_valid && in_ready:
  - Register a, beff and op. beff = in_b for add, ~in_b for sub.
  - Set carry register to in_op.
  - Counter = 0.
- CALC, each cycle:
  - Sum chunk[k] = a[k] + beff[k] + carry.
  - Write the CHUNK-bit sum into result[k·CHUNK +: CHUNK].
  - Carry ← chunk carry out; k ← k+1.
  - After chunk NCHUNK−1 go to DONE.
- DONE:
  - Outputs are held stable until out_valid && out_ready.
  - Then go to IDLE.
  - There is no bypass: in_ready rises the cycle after the output handshake.
- Flags are computed when entering DONE:
  - out_carry = final carry XOR op.
  - out_overflow = (a[MSB] == beff[MSB]) && (result[MSB] != a[MSB]).
  - out_zero = ~|result.
- Input values are ignored outside the IDLE handshake. in_a, in_b and in_op may change freely during CALC/DONE.
- in_valid held high in DONE does nothing until the unit returns to IDLE.
- Reset mid-CALC or mid-DONE:
  - The operation is discarded and no result is emitted.
  - The unit returns to IDLE.

## Timing
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0.
  - out_result = 0, out_carry = 0, out_overflow = 0, out_zero = 0.
  - carry register = 0, counter = 0.
- in_ready and out_valid are decoded directly from the state register; neither depends combinationally on any input.
- Latency: operands accepted at edge E → out_valid high after edge E+NCHUNK. For example, 2 cycles at WIDTH = 8, CHUNK = 4.
- Minimum issue interval is NCHUNK+2 cycles (accept, NCHUNK calc, handshake, one IDLE cycle).
- out_result, the flags and out_valid change only at state transitions. They are stable throughout DONE.
- out_ready is a don't-care outside DONE.

## Test plan
All cases use WIDTH=8, CHUNK=4 unless stated.
- **Add signed overflow:** add 0x7F + 0x01 → result 0x80, overflow 1, carry 0, zero 0. out_valid is asserted exactly 2 cycles after the accept edge.
- **Add wrap to zero:** add 0xFF + 0x01 → result 0x00, carry 1, zero 1, overflow 0.
- **Sub with borrow and signed overflow:**
  - sub 0x05 − 0x07 → result 0xFE, carry (borrow) 1, overflow 0.
  - sub 0x80 − 0x01 → result 0x7F, borrow 0, overflow 1.
  - sub 0x3C − 0x3C → result 0x00, zero 1, borrow 0.
- **Backpressure:** hold out_ready = 0 for 5 cycles in DONE while driving in_valid = 1 with new operands → result and flags stay constant, in_ready = 0, new operands are not captured. Release out_ready → in_ready = 1 on the next cycle; the next accept uses the then-current inputs.
- **Reset mid-CALC:** pulse rst_n low asynchronously (between edges) during CALC → out_valid = 0, in_ready = 1 and all outputs = 0 immediately; no stale result appears afterwards.
- **Reparametrisation:** WIDTH=16, CHUNK=1, sub 0x0000 − 0x0001 → result 0xFFFF, borrow 1, overflow 0, 16-cycle latency.
- **Randomised sweep:** random sweep against a reference model on the WIDTH=16, CHUNK=1 build.
